pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Program-counter sequencer for the pipelined MIPS core that runs the VBSME kernels. It owns the PC register and decides each cycle among increment, stall, branch, jump, jump-register and address-error trap. It computes branch and jump targets by shifting word offsets left by 2 and emits the flush pulse that squashes wrong-path fetches. It sits between the IF stage and the branch-resolution logic in ID/EX.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded by reset.
- EXC_VECTOR, 32'h0000_0180, PC loaded on a misaligned jump-register target.

Ports. One clock; reset is synchronous and active-high.
- Clk  in  1  rising-edge clock.
- Rst  in  1  synchronous, active-high reset.
- Stall  in  1  hazard unit holds fetch.
- BranchTaken  in  1  EX-stage branch resolved taken.
- BranchImm  in  16  branch word offset, signed.
- BranchPCPlus4  in  32  PC+4 of the branch instruction.
- Jump  in  1  ID-stage J/JAL.
- JumpIndex  in  26  instruction index field.
- JumpPCPlus4  in  32  PC+4 of the jump instruction.
- JumpReg  in  1  EX-stage JR/JALR.
- JumpRegAddr  in  32  register target.
- ErrAck  in  1  trap handler acknowledge.
- PC  out  32  current fetch address.
- PCPlus4  out  32  PC + 4, combinational from PC.
- Flush  out  1  squash IF/ID (and ID/EX for EX-stage redirects).
- AddrErr  out  1  misaligned-target trap active.

## Operation
- States: RUN, TRAP.
- Branch target: BranchPCPlus4 + ({{14{BranchImm[15]}}, BranchImm} << 2), modulo 2^32.
- Jump target: {JumpPCPlus4[31:28], JumpIndex, 2'b00}.
- Priority in RUN, highest first:
  1. Rst.
  2. JumpReg.
     - If JumpRegAddr[1:0] != 0: PC <= EXC_VECTOR, go to TRAP.
     - Otherwise: PC <= JumpRegAddr.
  3. BranchTaken: PC <= branch target.
  4. Jump: PC <= jump target.
  5. Stall: PC holds.
  6. Otherwise: PC <= PC + 4, wrapping from 32'hFFFF_FFFC to 0.
- JumpReg and BranchTaken are both EX-stage and mutually exclusive.
  - If both are asserted, JumpReg wins.
  - The bench flags simultaneous assertion as a protocol violation but still checks the JumpReg result.
- An EX redirect overrides Jump and Stall in the same cycle, because the younger instructions are being squashed.
- Flush is registered.
  - It is 1 in the cycle after any redirect (rows 2–4) and 0 otherwise.
  - It is also held at 1 for every cycle in TRAP.
- TRAP:
  - PC holds EXC_VECTOR and AddrErr = 1.
  - All redirect and Stall inputs are ignored.
  - On ErrAck: go to RUN, PC <= EXC_VECTOR + 4, AddrErr <= 0.
- Reset values: PC = RESET_PC, Flush = 0, AddrErr = 0, state = RUN.

## Timing
- All decisions are taken at the rising edge of Clk. The new PC is visible the cycle after the request.
- Redirect latency is 1 cycle, plus exactly 1 Flush cycle.
- Stall costs 0 extra cycles: the PC resumes incrementing the cycle after Stall drops.
- Rst asserted mid-redirect or in TRAP overrides everything on that edge. The next cycle shows reset values, with no Flush.
- PCPlus4 follows PC combinationally, with no added latency.

## Structure
- Shared package holds:
  - RESET_PC and EXC_VECTOR defaults.
  - The RUN/TRAP state encoding.
  - A 2-bit redirect-cause code (NONE, JR, BR, J) for debug visibility.
- One natural sub-module: pc_target_calc. It is purely combinational, contains the sign-extend, the <<2 operations and the branch adder, and produces the branch and jump targets.
- The FSM and PC register live in pc_sequencer.

## Test plan
- **Reset and increment:** Rst for 2 cycles, then release. PC reads 0, 4, 8, 12 and Flush stays 0.
- **Branch:** BranchTaken with BranchPCPlus4 = 0x0000_0100 and BranchImm = 0xFFFE. Next PC = 0x0000_00F8, Flush = 1 for one cycle, then PC = 0x0000_00FC.
- **Jump:** Jump with JumpPCPlus4 = 0x4000_0010 and JumpIndex = 26'h000_0040. Next PC = 0x4000_0100.
- **Priority:** BranchTaken (target 0x200), Jump and Stall all asserted together. Next PC = 0x200 and Flush = 1.
- **Stall:** Stall held 3 cycles at PC = 0x40. PC stays 0x40, then continues 0x44, 0x48.
- **Trap:**
  - JumpReg with JumpRegAddr = 0x0000_1002 gives PC = 0x180 with AddrErr = Flush = 1, and both hold for 4 cycles despite BranchTaken.
  - ErrAck then gives PC = 0x184 with AddrErr = 0.
  - Rst asserted in TRAP gives PC = 0 with AddrErr = 0.
- **Wrap:** PC = 0xFFFF_FFFC with no events. Next PC = 0.

Source files
------------

// File: rtl/pc_sequencer_pkg.sv
// pc_sequencer_pkg
// Shared definitions for the program-counter sequencer: default reset and
// exception vectors, the RUN/TRAP state encoding, the redirect-cause code
// and the debug struct exported by the sequencer.
package pc_sequencer_pkg;

  localparam logic [31:0] RESET_PC_DEF   = 32'h0000_0000;
  localparam logic [31:0] EXC_VECTOR_DEF = 32'h0000_0180;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_TRAP = 1'b1
  } pc_state_t;

  // Which redirect source won arbitration this cycle.
  typedef enum logic [1:0] {
    CAUSE_NONE = 2'd0,
    CAUSE_JR   = 2'd1,
    CAUSE_BR   = 2'd2,
    CAUSE_J    = 2'd3
  } redirect_cause_t;

  typedef struct packed {
    pc_state_t       state;
    redirect_cause_t cause;
  } pc_dbg_t;

endpackage

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if
// Bundles the control/target inputs coming from the hazard unit and the
// ID/EX branch-resolution logic, plus the PC-side outputs.
//   master : hazard/branch logic (drives requests, observes PC/Flush/AddrErr)
//   slave  : pc_sequencer
// Handshake: there is no valid/ready pair; every request input is a
// level qualified by its own enable (Stall, BranchTaken, Jump, JumpReg,
// ErrAck) and is sampled on every rising edge of Clk. The associated
// target fields only need to be stable while their enable is high.
interface pc_sequencer_if;
  logic        Stall;
  logic        BranchTaken;
  logic [15:0] BranchImm;
  logic [31:0] BranchPCPlus4;
  logic        Jump;
  logic [25:0] JumpIndex;
  logic [31:0] JumpPCPlus4;
  logic        JumpReg;
  logic [31:0] JumpRegAddr;
  logic        ErrAck;
  logic [31:0] PC;
  logic [31:0] PCPlus4;
  logic        Flush;
  logic        AddrErr;

  modport master (
    output Stall, BranchTaken, BranchImm, BranchPCPlus4,
           Jump, JumpIndex, JumpPCPlus4, JumpReg, JumpRegAddr, ErrAck,
    input  PC, PCPlus4, Flush, AddrErr
  );

  modport slave (
    input  Stall, BranchTaken, BranchImm, BranchPCPlus4,
           Jump, JumpIndex, JumpPCPlus4, JumpReg, JumpRegAddr, ErrAck,
    output PC, PCPlus4, Flush, AddrErr
  );
endinterface

// File: rtl/pc_target_calc.sv
// pc_target_calc
// Purely combinational target generation.
//   i_branch_imm      : signed branch word offset
//   i_branch_pc_plus4 : PC+4 of the branch instruction
//   i_jump_region     : upper 4 bits of PC+4 of the jump instruction
//   i_jump_index      : 26-bit J/JAL instruction index
//   o_branch_target   : i_branch_pc_plus4 + (sext(imm) << 2), mod 2^32
//   o_jump_target     : {region, index, 2'b00}
module pc_target_calc (
  input  logic [15:0] i_branch_imm,
  input  logic [31:0] i_branch_pc_plus4,
  input  logic [3:0]  i_jump_region,
  input  logic [25:0] i_jump_index,
  output logic [31:0] o_branch_target,
  output logic [31:0] o_jump_target
);

  logic [31:0] w_branch_off;

  // Sign-extend to 30 bits, then the word-to-byte shift fills two zeros.
  assign w_branch_off    = {{14{i_branch_imm[15]}}, i_branch_imm, 2'b00};
  assign o_branch_target = i_branch_pc_plus4 + w_branch_off;
  assign o_jump_target   = {i_jump_region, i_jump_index, 2'b00};

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer
// Owns the fetch PC. Each cycle it chooses among reset, jump-register
// (with misaligned-target trap), taken branch, jump, stall and increment,
// and produces a registered Flush pulse that squashes wrong-path fetches.
// Ports:
//   Clk, Rst : clock and synchronous active-high reset
//   bus      : pc_sequencer_if.slave (requests in, PC/PCPlus4/Flush/AddrErr out)
//   o_dbg    : current FSM state and the redirect cause chosen this cycle
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF
) (
  input  logic                 Clk,
  input  logic                 Rst,
  pc_sequencer_if.slave        bus,
  output pc_dbg_t              o_dbg
);

  pc_state_t       r_state, w_state_next;
  logic [31:0]     r_pc, w_pc_next;
  logic            r_flush, w_flush_next;
  logic            r_addr_err, w_addr_err_next;
  redirect_cause_t w_cause;

  logic [31:0]     w_branch_target;
  logic [31:0]     w_jump_target;
  logic            w_unused_ok;

  pc_target_calc u_target_calc (
    .i_branch_imm      (bus.BranchImm),
    .i_branch_pc_plus4 (bus.BranchPCPlus4),
    .i_jump_region     (bus.JumpPCPlus4[31:28]),
    .i_jump_index      (bus.JumpIndex),
    .o_branch_target   (w_branch_target),
    .o_jump_target     (w_jump_target)
  );

  // Only the region bits of the jump's PC+4 matter for the target.
  assign w_unused_ok = &{1'b0, bus.JumpPCPlus4[27:0]};

  // State register
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state    <= ST_RUN;
      r_pc       <= RESET_PC;
      r_flush    <= 1'b0;
      r_addr_err <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_pc       <= w_pc_next;
      r_flush    <= w_flush_next;
      r_addr_err <= w_addr_err_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next    = r_state;
    w_pc_next       = r_pc;
    w_flush_next    = 1'b0;
    w_addr_err_next = r_addr_err;
    w_cause         = CAUSE_NONE;
    unique case (r_state)
      ST_RUN: begin
        // EX-stage redirects beat Jump and Stall: the younger instructions
        // that raised them are being squashed anyway.
        if (bus.JumpReg) begin
          w_cause      = CAUSE_JR;
          w_flush_next = 1'b1;
          if (bus.JumpRegAddr[1:0] != 2'b00) begin
            w_state_next    = ST_TRAP;
            w_pc_next       = EXC_VECTOR;
            w_addr_err_next = 1'b1;
          end else begin
            w_pc_next = bus.JumpRegAddr;
          end
        end else if (bus.BranchTaken) begin
          w_cause      = CAUSE_BR;
          w_flush_next = 1'b1;
          w_pc_next    = w_branch_target;
        end else if (bus.Jump) begin
          w_cause      = CAUSE_J;
          w_flush_next = 1'b1;
          w_pc_next    = w_jump_target;
        end else if (!bus.Stall) begin
          w_pc_next = r_pc + 32'd4;
        end
      end
      ST_TRAP: begin
        // Flush stays high for the whole trap; all requests are ignored.
        w_pc_next    = EXC_VECTOR;
        w_flush_next = 1'b1;
        if (bus.ErrAck) begin
          w_state_next    = ST_RUN;
          w_pc_next       = EXC_VECTOR + 32'd4;
          w_flush_next    = 1'b0;
          w_addr_err_next = 1'b0;
        end
      end
      default: begin
        w_state_next = ST_RUN;
      end
    endcase
  end

  // Output logic
  always_comb begin
    bus.PC        = r_pc;
    bus.PCPlus4   = r_pc + 32'd4;
    bus.Flush     = r_flush;
    bus.AddrErr   = r_addr_err;
    o_dbg.state   = r_state;
    o_dbg.cause   = w_cause;
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer
// Directed vectors with hand-computed expected PC/Flush/AddrErr values.
module tb_pc_sequencer;
  import pc_sequencer_pkg::*;

  logic    clk;
  logic    rst;
  pc_dbg_t dbg;

  int n_cmp;
  int n_err;

  pc_sequencer_if bus ();

  pc_sequencer #(
    .RESET_PC   (32'h0000_0000),
    .EXC_VECTOR (32'h0000_0180)
  ) dut (
    .Clk   (clk),
    .Rst   (rst),
    .bus   (bus),
    .o_dbg (dbg)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Checker
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag, input logic [31:0] pc,
                             input logic flush, input logic aerr);
    check({tag, ".pc"},    bus.PC,                pc);
    check({tag, ".flush"}, {31'd0, bus.Flush},    {31'd0, flush});
    check({tag, ".aerr"},  {31'd0, bus.AddrErr},  {31'd0, aerr});
  endtask

  // Drivers
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.Stall         = 1'b0;
    bus.BranchTaken   = 1'b0;
    bus.BranchImm     = 16'h0000;
    bus.BranchPCPlus4 = 32'h0;
    bus.Jump          = 1'b0;
    bus.JumpIndex     = 26'h0;
    bus.JumpPCPlus4   = 32'h0;
    bus.JumpReg       = 1'b0;
    bus.JumpRegAddr   = 32'h0;
    bus.ErrAck        = 1'b0;
  endtask

  task automatic do_jr(input logic [31:0] addr);
    bus.JumpReg     = 1'b1;
    bus.JumpRegAddr = addr;
    step();
    bus.JumpReg     = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    idle_inputs();
    rst = 1'b1;

    // Reset and increment
    step();
    step();
    check_state("reset", 32'h0, 1'b0, 1'b0);
    check("reset.pcp4", bus.PCPlus4, 32'h4);
    check("reset.state", {31'd0, dbg.state}, {31'd0, ST_RUN});
    rst = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      step();
      check_state($sformatf("inc%0d", i), 32'(4 * i), 1'b0, 1'b0);
    end

    // Branch backwards by two words
    bus.BranchTaken   = 1'b1;
    bus.BranchPCPlus4 = 32'h0000_0100;
    bus.BranchImm     = 16'hFFFE;
    step();
    bus.BranchTaken = 1'b0;
    check_state("br", 32'h0000_00F8, 1'b1, 1'b0);
    check("br.pcp4", bus.PCPlus4, 32'h0000_00FC);
    step();
    check_state("br.next", 32'h0000_00FC, 1'b0, 1'b0);

    // Jump
    bus.Jump        = 1'b1;
    bus.JumpPCPlus4 = 32'h4000_0010;
    bus.JumpIndex   = 26'h000_0040;
    step();
    bus.Jump = 1'b0;
    check_state("j", 32'h4000_0100, 1'b1, 1'b0);
    step();
    check_state("j.next", 32'h4000_0104, 1'b0, 1'b0);

    // Branch beats Jump and Stall
    bus.BranchTaken   = 1'b1;
    bus.BranchPCPlus4 = 32'h0000_0100;
    bus.BranchImm     = 16'h0040;
    bus.Jump          = 1'b1;
    bus.Stall         = 1'b1;
    step();
    idle_inputs();
    check_state("prio", 32'h0000_0200, 1'b1, 1'b0);
    step();
    check_state("prio.next", 32'h0000_0204, 1'b0, 1'b0);

    // Stall for 3 cycles at 0x40
    do_jr(32'h0000_0040);
    check_state("jr40", 32'h0000_0040, 1'b1, 1'b0);
    bus.Stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_state($sformatf("stall%0d", i), 32'h0000_0040, 1'b0, 1'b0);
    end
    bus.Stall = 1'b0;
    step();
    check_state("unstall0", 32'h0000_0044, 1'b0, 1'b0);
    step();
    check_state("unstall1", 32'h0000_0048, 1'b0, 1'b0);

    // JumpReg and BranchTaken together: protocol violation, JumpReg wins
    bus.BranchTaken   = 1'b1;
    bus.BranchPCPlus4 = 32'h0000_0800;
    bus.BranchImm     = 16'h0001;
    if (bus.BranchTaken) $display("note: protocol violation, JumpReg and BranchTaken asserted together");
    do_jr(32'h0000_0300);
    bus.BranchTaken = 1'b0;
    check_state("jr_br", 32'h0000_0300, 1'b1, 1'b0);

    // Misaligned JumpReg traps; redirects ignored while trapped
    do_jr(32'h0000_1002);
    check_state("trap", 32'h0000_0180, 1'b1, 1'b1);
    check("trap.state", {31'd0, dbg.state}, {31'd0, ST_TRAP});
    bus.BranchTaken   = 1'b1;
    bus.BranchPCPlus4 = 32'h0000_0100;
    bus.BranchImm     = 16'h0004;
    bus.Jump          = 1'b1;
    bus.Stall         = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check_state($sformatf("trap_hold%0d", i), 32'h0000_0180, 1'b1, 1'b1);
    end
    idle_inputs();
    bus.ErrAck = 1'b1;
    step();
    bus.ErrAck = 1'b0;
    check_state("ack", 32'h0000_0184, 1'b0, 1'b0);
    check("ack.state", {31'd0, dbg.state}, {31'd0, ST_RUN});
    step();
    check_state("ack.next", 32'h0000_0188, 1'b0, 1'b0);

    // Reset while trapped
    do_jr(32'h0000_1001);
    check_state("trap2", 32'h0000_0180, 1'b1, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_state("trap_rst", 32'h0, 1'b0, 1'b0);
    step();
    check_state("trap_rst.next", 32'h4, 1'b0, 1'b0);

    // Reset during a redirect request
    bus.BranchTaken   = 1'b1;
    bus.BranchPCPlus4 = 32'h0000_0100;
    bus.BranchImm     = 16'h0010;
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.BranchTaken = 1'b0;
    check_state("br_rst", 32'h0, 1'b0, 1'b0);

    // Wrap at the top of the address space
    do_jr(32'hFFFF_FFFC);
    check_state("wrap_pre", 32'hFFFF_FFFC, 1'b1, 1'b0);
    check("wrap.pcp4", bus.PCPlus4, 32'h0);
    step();
    check_state("wrap", 32'h0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
